// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the round-robin FIFO transfer controller:
// FSM state encoding, port count and destination-field geometry.
package fifo_ctrl_pkg;

  // Number of source and destination FIFOs; the arbiter is built for exactly four.
  localparam int NUM_PORTS = 4;

  // Width of a port index (source or destination).
  localparam int IDX_W = 2;

  // The destination index occupies the DST_W most significant bits of a word.
  localparam int DST_W = 2;

  // Width of the OR-reduced error vector (four sources plus four destinations).
  localparam int ERR_W = 8;

  // Round-robin pointer value after reset, so that source 0 is searched first.
  localparam logic [IDX_W-1:0] LAST_RESET = 2'd3;

  // Controller states; the numeric values are visible on the state output.
  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Convert a port index into a one-hot strobe vector.
  function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_PORTS-1:0] one;
    one = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter, purely combinational.
// The search starts at the requester after 'last' and wraps around, so the
// previously granted requester is reconsidered only after every other one.
module rr_arbiter_4
  import fifo_ctrl_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] grant,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Walk last+1 .. last+4 (mod 4) and keep the first requester found.
  always_comb begin
    grant = '0;
    idx   = last;
    any   = 1'b0;
    cand  = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      grant = idx_to_onehot(idx);
    end
  end

endmodule

// File: rtl/fifo_arbiter_rr.sv
// Round-robin transfer controller between four source FIFOs and four
// destination FIFOs. One non-empty source is popped per cycle; the word it
// returns one cycle later is pushed to the destination named by its two MSBs.
// The controller also distributes the alto/bajo thresholds and freezes all
// traffic once any FIFO reports an error.
//
// Handshake: a pop is a single-cycle strobe that the source FIFO always
// accepts (it is only issued to a non-empty source); the source presents the
// word on src_data in the next cycle, and that same cycle carries the matching
// dst_push strobe and dst_data. Destinations never stall a push in flight:
// almost_full on any destination only prevents new pops.
module fifo_arbiter_rr
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_PORTS  = fifo_ctrl_pkg::NUM_PORTS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [2:0]                      alto_in,
  input  logic [2:0]                      bajo_in,
  output logic [2:0]                      alto,
  output logic [2:0]                      bajo,
  input  logic [NUM_PORTS-1:0]            src_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] src_data,
  output logic [NUM_PORTS-1:0]            src_pop,
  input  logic [NUM_PORTS-1:0]            dst_almost_full,
  output logic [NUM_PORTS-1:0]            dst_push,
  output logic [DATA_WIDTH-1:0]           dst_data,
  input  logic [ERR_W-1:0]                fifo_error,
  output logic [2:0]                      state,
  output logic                            idle
);

  // Registered state.
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  pend_q, pend_d;
  logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
  logic [2:0]            alto_q, alto_d;
  logic [2:0]            bajo_q, bajo_d;
  logic                  idle_q, idle_d;

  // Arbiter interface.
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;

  // Qualifiers.
  logic                  any_afull;
  logic                  any_err;
  logic                  pop_fire;
  logic                  push_live;
  logic [DATA_WIDTH-1:0] pend_word;

  assign req       = ~src_empty;
  assign any_afull = |dst_almost_full;
  assign any_err   = |fifo_error;

  rr_arbiter_4 u_arb (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A pop needs ACTIVE, no reconfiguration request, no almost-full anywhere
  // (the destination is not known until the word arrives) and no error this
  // cycle, so nothing new is launched on the cycle an error shows up.
  always_comb begin
    pop_fire = (state_q == ST_ACTIVE) && !init && !any_afull && !any_err && arb_any;
  end

  // Next-state selection; an error outranks every other transition except
  // leaving RESET, and ERROR is only left through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RESET) begin
      state_d = ST_INIT;
    end else if (any_err) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!init) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (init)                         state_d = ST_INIT;
          else if (arb_any && !any_afull)   state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                         state_d = ST_INIT;
          else if (!arb_any || any_afull)   state_d = ST_IDLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Pointer update and push pipeline: the granted index travels one cycle
  // alongside the pop so the returning word can be picked from the right source.
  always_comb begin
    last_d     = last_q;
    pend_d     = pop_fire;
    pend_idx_d = pend_idx_q;
    if (pop_fire) begin
      last_d     = arb_idx;
      pend_idx_d = arb_idx;
    end
  end

  // Thresholds follow the inputs for every cycle spent in INIT and hold otherwise.
  always_comb begin
    alto_d = alto_q;
    bajo_d = bajo_q;
    if (state_q == ST_INIT) begin
      alto_d = alto_in;
      bajo_d = bajo_in;
    end
    idle_d = (state_d == ST_IDLE);
  end

  // All controller flops; reset is asynchronous so a transfer in flight is
  // abandoned the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      last_q     <= LAST_RESET;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      alto_q     <= '0;
      bajo_q     <= '0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
      idle_q     <= idle_d;
    end
  end

  // Select the word returned by the source popped last cycle.
  always_comb begin
    pend_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pend_idx_q == IDX_W'(i)) begin
        pend_word = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A pending push completes in any state except ERROR, where it is dropped.
  always_comb begin
    push_live = pend_q && (state_q != ST_ERROR);
    dst_data  = push_live ? pend_word : '0;
    dst_push  = push_live ? idx_to_onehot(pend_word[DATA_WIDTH-1 -: DST_W]) : '0;
    src_pop   = pop_fire ? arb_grant : '0;
  end

  assign alto  = alto_q;
  assign bajo  = bajo_q;
  assign state = state_q;
  assign idle  = idle_q;

endmodule
